// File: rtl/pic_pkg.sv
// Types and bit positions shared by the PIC bus front end and ControlLogic.
package pic_pkg;

  typedef enum logic [1:0] {
    CMD_READY  = 2'd0,
    WRITE_ICW2 = 2'd1,
    WRITE_ICW3 = 2'd2,
    WRITE_ICW4 = 2'd3
  } command_state_t;

  localparam int ICW1_ID_BIT = 4;
  localparam int OCW3_ID_BIT = 3;
  localparam int SNGL_BIT    = 1;
  localparam int IC4_BIT     = 0;

  typedef struct packed {
    logic ocw3;
    logic ocw2;
    logic ocw1;
    logic icw4;
    logic icw3;
    logic icw2;
    logic icw1;
  } strobe_t;

endpackage

// File: rtl/pic_sync_edge.sv
// Multi-flop synchroniser for an active-low window; emits the active-high
// level together with single-cycle open (rise) and close (fall) pulses.
module pic_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_n_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              level_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q       <= '1;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[STAGES-2:0], sig_n_i};
      level_prev_q <= level_o;
    end
  end

  assign level_o = ~sync_q[STAGES-1];
  assign rise_o  = level_o & ~level_prev_q;
  assign fall_o  = ~level_o & level_prev_q;

endmodule

// File: rtl/pic_bus_write_decoder.sv
// CPU bus front end of the PIC: synchronises the bus strobes, captures each
// completed write and classifies it as ICW1..4 / OCW1..3 via the ICW sequencer.
module pic_bus_write_decoder
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CS_N,
  input  logic       WR_N,
  input  logic       RD_N,
  input  logic       A0,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       ICW1_RECEIVED,
  output logic       ICW2_RECEIVED,
  output logic       ICW3_RECEIVED,
  output logic       ICW4_RECEIVED,
  output logic       OCW1_RECEIVED,
  output logic       OCW2_RECEIVED,
  output logic       OCW3_RECEIVED,
  output logic       IN_INIT,
  output logic       READ_ACTIVE,
  output logic       READ_A0
);

  logic wr_lvl, wr_rise, wr_fall;
  logic rd_lvl, rd_rise, rd_fall;

  pic_sync_edge #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .sig_n_i (CS_N | WR_N),
    .level_o (wr_lvl),
    .rise_o  (wr_rise),
    .fall_o  (wr_fall)
  );

  pic_sync_edge #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .sig_n_i (CS_N | RD_N),
    .level_o (rd_lvl),
    .rise_o  (rd_rise),
    .fall_o  (rd_fall)
  );

  command_state_t state_q, state_d;
  logic           sngl_q, sngl_d, ic4_q, ic4_d;
  logic [7:0]     shadow_data_q, shadow_data_d;
  logic           shadow_a0_q, shadow_a0_d;
  logic           collide_q, collide_d;
  logic           armed_q, armed_d;
  logic [2:0]     settle_q, settle_d;
  strobe_t        strobe_q, strobe_d;
  logic [7:0]     data_out_q, data_out_d;
  logic           read_active_q, read_active_d;
  logic           read_a0_q, read_a0_d;
  logic           accept, hit;

  // A window still open when reset releases must be seen closing before the
  // next one counts; settle_q waits until the chain holds post-reset samples.
  always_comb begin
    settle_d = settle_q;
    if (settle_q != 3'(SYNC_STAGES)) settle_d = settle_q + 3'd1;
    armed_d = armed_q | ((settle_q == 3'(SYNC_STAGES)) & ~wr_lvl);
  end

  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_a0_d   = shadow_a0_q;
    collide_d     = collide_q;
    if (wr_lvl) begin
      shadow_data_d = DATA_IN;
      shadow_a0_d   = A0;
      collide_d     = wr_rise ? rd_lvl : (collide_q | rd_lvl);
    end
  end

  assign accept = wr_fall & armed_q & ~collide_q;

  always_comb begin
    strobe_d   = '0;
    state_d    = state_q;
    sngl_d     = sngl_q;
    ic4_d      = ic4_q;
    data_out_d = data_out_q;
    hit        = 1'b0;
    if (accept) begin
      if (!shadow_a0_q && shadow_data_q[ICW1_ID_BIT]) begin
        strobe_d.icw1 = 1'b1;
        state_d       = WRITE_ICW2;
        sngl_d        = shadow_data_q[SNGL_BIT];
        ic4_d         = shadow_data_q[IC4_BIT];
        hit           = 1'b1;
      end else begin
        case (state_q)
          CMD_READY: begin
            hit = 1'b1;
            if (shadow_a0_q)                       strobe_d.ocw1 = 1'b1;
            else if (shadow_data_q[OCW3_ID_BIT])   strobe_d.ocw3 = 1'b1;
            else                                   strobe_d.ocw2 = 1'b1;
          end
          WRITE_ICW2: if (shadow_a0_q) begin
            hit           = 1'b1;
            strobe_d.icw2 = 1'b1;
            state_d       = !sngl_q ? WRITE_ICW3 : (ic4_q ? WRITE_ICW4 : CMD_READY);
          end
          WRITE_ICW3: if (shadow_a0_q) begin
            hit           = 1'b1;
            strobe_d.icw3 = 1'b1;
            state_d       = ic4_q ? WRITE_ICW4 : CMD_READY;
          end
          WRITE_ICW4: if (shadow_a0_q) begin
            hit           = 1'b1;
            strobe_d.icw4 = 1'b1;
            state_d       = CMD_READY;
          end
          default: state_d = CMD_READY;
        endcase
      end
      if (hit) data_out_d = shadow_data_q;
    end
  end

  always_comb begin
    read_active_d = read_active_q;
    if (rd_rise)      read_active_d = 1'b1;
    else if (rd_fall) read_active_d = 1'b0;
    read_a0_d = rd_rise ? A0 : read_a0_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= CMD_READY;
      sngl_q        <= 1'b0;
      ic4_q         <= 1'b0;
      shadow_data_q <= 8'h00;
      shadow_a0_q   <= 1'b0;
      collide_q     <= 1'b0;
      armed_q       <= 1'b0;
      settle_q      <= 3'd0;
      strobe_q      <= '0;
      data_out_q    <= 8'h00;
      read_active_q <= 1'b0;
      read_a0_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sngl_q        <= sngl_d;
      ic4_q         <= ic4_d;
      shadow_data_q <= shadow_data_d;
      shadow_a0_q   <= shadow_a0_d;
      collide_q     <= collide_d;
      armed_q       <= armed_d;
      settle_q      <= settle_d;
      strobe_q      <= strobe_d;
      data_out_q    <= data_out_d;
      read_active_q <= read_active_d;
      read_a0_q     <= read_a0_d;
    end
  end

  assign DATA_OUT      = data_out_q;
  assign ICW1_RECEIVED = strobe_q.icw1;
  assign ICW2_RECEIVED = strobe_q.icw2;
  assign ICW3_RECEIVED = strobe_q.icw3;
  assign ICW4_RECEIVED = strobe_q.icw4;
  assign OCW1_RECEIVED = strobe_q.ocw1;
  assign OCW2_RECEIVED = strobe_q.ocw2;
  assign OCW3_RECEIVED = strobe_q.ocw3;
  assign IN_INIT       = (state_q != CMD_READY);
  assign READ_ACTIVE   = read_active_q;
  assign READ_A0       = read_a0_q;

endmodule
